// File: rtl/conv_pkg.sv
// Shared sizing, state encoding and configuration-word layout for the conv
// strip controller and its counter block.
package conv_pkg;

    localparam int unsigned COLS_DEF   = 48;
    localparam int unsigned STRIPS_DEF = 16;
    localparam int unsigned DRAIN_DEF  = 8;

    localparam int unsigned COL_W   = 6;
    localparam int unsigned STRIP_W = 4;
    localparam int unsigned IC_W    = 6;
    localparam int unsigned CFG_W   = 80;
    localparam int unsigned ROW_W   = 24;
    localparam int unsigned WIN_W   = 5 * ROW_W;

    localparam int unsigned CFG_BIAS_LSB = 72;
    localparam int unsigned CFG_BIAS_W   = 8;
    localparam int unsigned CFG_WGT_LSB  = 0;
    localparam int unsigned CFG_WGT_W    = 72;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_STREAM,
        S_DRAIN,
        S_ROWDONE,
        S_SEND,
        S_WAIT_TX
    } state_t;

    function automatic logic [CFG_BIAS_W-1:0] cfg_bias(input logic [CFG_W-1:0] d);
        return d[CFG_BIAS_LSB +: CFG_BIAS_W];
    endfunction

    function automatic logic [CFG_WGT_W-1:0] cfg_weights(input logic [CFG_W-1:0] d);
        return d[CFG_WGT_LSB +: CFG_WGT_W];
    endfunction

    // Row 1 sits in the most significant slice of the window word.
    function automatic logic [ROW_W-1:0] win_row(input logic [WIN_W-1:0] win,
                                                 input int unsigned idx);
        return win[WIN_W - ROW_W * (idx + 1) +: ROW_W];
    endfunction

endpackage

// File: rtl/conv_ctrl_if.sv
// Configuration handshake and window-source read bus between conv_ctrl and
// its configuration/window providers.
interface conv_ctrl_if;
    import conv_pkg::*;

    logic               i_cfg_valid;
    logic               o_cfg_ready;
    logic [CFG_W-1:0]   i_cfg_data;
    logic               o_win_rd;
    logic [STRIP_W-1:0] o_win_strip;
    logic [COL_W-1:0]   o_win_col;
    logic [WIN_W-1:0]   i_win_data;

    modport slave (
        input  i_cfg_valid, i_cfg_data, i_win_data,
        output o_cfg_ready, o_win_rd, o_win_strip, o_win_col
    );

    modport master (
        output i_cfg_valid, i_cfg_data, i_win_data,
        input  o_cfg_ready, o_win_rd, o_win_strip, o_win_col
    );

endinterface

// File: rtl/conv_ctrl_cnt.sv
// Column, strip and drain counters for conv_ctrl; sequencing decisions stay
// in the parent FSM, this block only counts and flags terminal values.
module conv_ctrl_cnt import conv_pkg::*; #(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned STRIPS = STRIPS_DEF,
    parameter int unsigned DRAIN  = DRAIN_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               col_en,
    input  logic               strip_inc,
    input  logic               drain_en,
    output logic [COL_W-1:0]   col,
    output logic [STRIP_W-1:0] strip,
    output logic               col_last,
    output logic               strip_last,
    output logic               drain_done
);

    localparam int unsigned DCNT_W = $clog2(DRAIN + 1);

    logic [DCNT_W-1:0] dcnt;

    assign col_last   = (col == COL_W'(COLS - 1));
    assign strip_last = (strip == STRIP_W'(STRIPS - 1));
    assign drain_done = (dcnt == DCNT_W'(DRAIN));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col <= '0;
        end else if (clr) begin
            col <= '0;
        end else if (col_en) begin
            col <= col_last ? '0 : col + 1'b1;
        end
    end

    // Strip holds at its last value after the final strip; only a new start clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strip <= '0;
        end else if (clr) begin
            strip <= '0;
        end else if (strip_inc && !strip_last) begin
            strip <= strip + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
        end else begin
            dcnt <= drain_en ? dcnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/conv_ctrl.sv
// Strip-sequencing controller for the conv engine: takes one configuration
// word, streams COLS windows per strip for STRIPS strips, then awaits the
// end of the output transfer.
module conv_ctrl import conv_pkg::*; #(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned STRIPS = STRIPS_DEF,
    parameter int unsigned DRAIN  = DRAIN_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [IC_W-1:0]  i_ic,
    conv_ctrl_if.slave       bus,
    output logic [CFG_W-1:0] o_params,
    output logic             o_params_valid,
    output logic [IC_W-1:0]  o_current_ic,
    output logic [ROW_W-1:0] o_pe_1_row,
    output logic [ROW_W-1:0] o_pe_2_row,
    output logic [ROW_W-1:0] o_pe_3_row,
    output logic [ROW_W-1:0] o_pe_4_row,
    output logic [ROW_W-1:0] o_pe_5_row,
    output logic             o_pe_valid,
    output logic             o_img_row_done,
    output logic             o_send_flg,
    input  logic             i_tvalid,
    input  logic             i_tready,
    input  logic             i_tlast,
    output logic             o_busy,
    output logic             o_done
);

    state_t state, state_nxt;

    logic start_acc;
    logic cfg_ready;
    logic cfg_fire;
    logic win_rd;
    logic row_done;
    logic send;
    logic tx_fire;
    logic rd_q;

    logic [COL_W-1:0]   col;
    logic [STRIP_W-1:0] strip;
    logic               col_last;
    logic               strip_last;
    logic               drain_done;

    conv_ctrl_cnt #(
        .COLS   (COLS),
        .STRIPS (STRIPS),
        .DRAIN  (DRAIN)
    ) u_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (start_acc),
        .col_en     (win_rd),
        .strip_inc  (row_done),
        .drain_en   (state == S_DRAIN),
        .col        (col),
        .strip      (strip),
        .col_last   (col_last),
        .strip_last (strip_last),
        .drain_done (drain_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        cfg_ready = 1'b0;
        cfg_fire  = 1'b0;
        win_rd    = 1'b0;
        row_done  = 1'b0;
        send      = 1'b0;
        tx_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = S_CFG;
                end
            end
            S_CFG: begin
                cfg_ready = 1'b1;
                cfg_fire  = bus.i_cfg_valid;
                if (bus.i_cfg_valid) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                win_rd = 1'b1;
                if (col_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            // Drain count starts one cycle before the final PE beat, so reaching
            // DRAIN puts ROWDONE exactly DRAIN cycles after that beat.
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_ROWDONE;
                end
            end
            S_ROWDONE: begin
                row_done  = 1'b1;
                state_nxt = strip_last ? S_SEND : S_STREAM;
            end
            S_SEND: begin
                send      = 1'b1;
                state_nxt = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                tx_fire = i_tvalid && i_tready && i_tlast;
                if (tx_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.o_cfg_ready = cfg_ready;
    assign bus.o_win_rd    = win_rd;
    assign bus.o_win_strip = strip;
    assign bus.o_win_col   = col;
    assign o_img_row_done  = row_done;
    assign o_send_flg      = send;
    assign o_busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_current_ic   <= '0;
            o_params       <= '0;
            o_params_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            if (start_acc) begin
                o_current_ic <= i_ic;
            end
            if (cfg_fire) begin
                o_params <= {cfg_bias(bus.i_cfg_data), cfg_weights(bus.i_cfg_data)};
            end
            o_params_valid <= cfg_fire;
            o_done         <= tx_fire;
        end
    end

    // Window data arrives the cycle after the read strobe; rd_q marks it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q       <= 1'b0;
            o_pe_valid <= 1'b0;
            o_pe_1_row <= '0;
            o_pe_2_row <= '0;
            o_pe_3_row <= '0;
            o_pe_4_row <= '0;
            o_pe_5_row <= '0;
        end else begin
            rd_q       <= win_rd;
            o_pe_valid <= rd_q;
            if (rd_q) begin
                o_pe_1_row <= win_row(bus.i_win_data, 0);
                o_pe_2_row <= win_row(bus.i_win_data, 1);
                o_pe_3_row <= win_row(bus.i_win_data, 2);
                o_pe_4_row <= win_row(bus.i_win_data, 3);
                o_pe_5_row <= win_row(bus.i_win_data, 4);
            end
        end
    end

endmodule
